ga_gen_ctrl: RTL and testbench

Generation controller for the GA pipeline. It sequences the run through three phases: random initial population, steady-state generations fed back from the offspring buffer, and termination. It counts evaluated chromosome pairs per generation and tracks the best chromosome and its fitness. It ends the run on a generation limit, on stagnation, or on reaching a target fitness. It sits beside the fitness stage and drives the source select and the pipeline enable.

---
 rtl/ga_pkg.sv | 16 +
 rtl/ga_best_tracker.sv | 81 ++++++++
 rtl/ga_gen_ctrl.sv | 132 +++++++++++++
 tb/tb_ga_gen_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared types and constants for the GA generation controller slice.
package ga_pkg;

    localparam int CHROM_W = 8;
    localparam int FIT_W   = 27;

    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ga_best_tracker.sv
// Pairwise max of an evaluated pair folded into a registered running best.
// One cycle from pair_vld_i to updated best; tracks whether the current generation improved.
module ga_best_tracker #(
    parameter int CHROM_W = 8,
    parameter int FIT_W   = 27
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      pair_vld_i,
    input  logic                      gen_end_i,
    input  logic [CHROM_W-1:0]        chrom1_i,
    input  logic [CHROM_W-1:0]        chrom2_i,
    input  logic signed [FIT_W-1:0]   fit1_i,
    input  logic signed [FIT_W-1:0]   fit2_i,
    output logic [CHROM_W-1:0]        best_o,
    output logic signed [FIT_W-1:0]   best_fit_o,
    output logic signed [FIT_W-1:0]   best_fit_nxt_o,
    output logic                      gen_improved_o
);

    localparam logic signed [FIT_W-1:0] FIT_LOW = {1'b1, {(FIT_W-1){1'b0}}};

    logic [CHROM_W-1:0]      best_q, best_d;
    logic signed [FIT_W-1:0] best_fit_q, best_fit_d;
    logic                    improved_q, improved_d;
    logic [CHROM_W-1:0]      cand_chrom;
    logic signed [FIT_W-1:0] cand_fit;
    logic                    better;

    // Ties go to chrom1.
    always_comb begin
        if (fit1_i >= fit2_i) begin
            cand_chrom = chrom1_i;
            cand_fit   = fit1_i;
        end else begin
            cand_chrom = chrom2_i;
            cand_fit   = fit2_i;
        end
    end

    assign better = pair_vld_i && (cand_fit > best_fit_q);

    always_comb begin
        best_d     = best_q;
        best_fit_d = best_fit_q;
        improved_d = improved_q;
        if (clear_i) begin
            best_d     = '0;
            best_fit_d = FIT_LOW;
            improved_d = 1'b0;
        end else begin
            if (better) begin
                best_d     = cand_chrom;
                best_fit_d = cand_fit;
                improved_d = 1'b1;
            end
            if (gen_end_i) begin
                improved_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_q     <= '0;
            best_fit_q <= FIT_LOW;
            improved_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            best_fit_q <= best_fit_d;
            improved_q <= improved_d;
        end
    end

    assign best_o         = best_q;
    assign best_fit_o     = best_fit_q;
    assign best_fit_nxt_o = best_fit_d;
    assign gen_improved_o = improved_q | better;

endmodule

// File: rtl/ga_gen_ctrl.sv
// GA run sequencer: initial population, steady-state generations, termination.
// Counts pairs per generation and ends the run on generation limit, stagnation or target.
module ga_gen_ctrl #(
    parameter int POP_SIZE    = 16,
    parameter int CHROM_W     = 8,
    parameter int FIT_W       = 27,
    parameter int GEN_W       = 16,
    parameter int MAX_GENS    = 100,
    parameter int STALL_LIMIT = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pair_valid,
    input  logic [CHROM_W-1:0]        chrom1,
    input  logic [CHROM_W-1:0]        chrom2,
    input  logic signed [FIT_W-1:0]   fit1,
    input  logic signed [FIT_W-1:0]   fit2,
    input  logic                      target_en,
    input  logic signed [FIT_W-1:0]   target_fit,
    output logic                      src_sel,
    output logic                      pipe_enable,
    output logic                      busy,
    output logic                      done,
    output logic [GEN_W-1:0]          gen_count,
    output logic [CHROM_W-1:0]        best,
    output logic signed [FIT_W-1:0]   best_fit
);

    import ga_pkg::*;

    localparam int PAIRS = POP_SIZE / 2;
    localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ST_W  = $clog2(STALL_LIMIT + 1);

    state_t                  state_q, state_d;
    logic [PC_W-1:0]         pair_cnt_q, pair_cnt_d;
    logic [ST_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [GEN_W-1:0]        gen_count_q, gen_count_d;
    logic                    src_sel_q, pipe_enable_q, busy_q, done_q;

    logic                    pair_acc;
    logic                    start_acc;
    logic                    gen_end;
    logic                    terminate;
    logic                    gen_improved;
    logic signed [FIT_W-1:0] best_fit_nxt;

    assign pair_acc  = pair_valid && ((state_q == S_INIT) || (state_q == S_RUN));
    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign gen_end   = pair_acc && (pair_cnt_q == PC_W'(PAIRS - 1));

    ga_best_tracker #(
        .CHROM_W (CHROM_W),
        .FIT_W   (FIT_W)
    ) u_best (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (start_acc),
        .pair_vld_i     (pair_acc),
        .gen_end_i      (gen_end),
        .chrom1_i       (chrom1),
        .chrom2_i       (chrom2),
        .fit1_i         (fit1),
        .fit2_i         (fit2),
        .best_o         (best),
        .best_fit_o     (best_fit),
        .best_fit_nxt_o (best_fit_nxt),
        .gen_improved_o (gen_improved)
    );

    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        stall_cnt_d = stall_cnt_q;
        gen_count_d = gen_count_q;
        terminate   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d     = S_INIT;
                    pair_cnt_d  = '0;
                    stall_cnt_d = '0;
                    gen_count_d = '0;
                end
            end
            default: begin
                if (gen_end) begin
                    pair_cnt_d  = '0;
                    gen_count_d = gen_count_q + 1'b1;
                    stall_cnt_d = gen_improved ? '0 : stall_cnt_q + 1'b1;
                    // Termination looks at the values this edge will commit.
                    terminate   = (gen_count_d == GEN_W'(MAX_GENS))
                               || (stall_cnt_d == ST_W'(STALL_LIMIT))
                               || (target_en && (best_fit_nxt >= target_fit));
                    state_d     = terminate ? S_DONE : S_RUN;
                end else if (pair_acc) begin
                    pair_cnt_d = pair_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pair_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            gen_count_q   <= '0;
            src_sel_q     <= 1'b0;
            pipe_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pair_cnt_q    <= pair_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            gen_count_q   <= gen_count_d;
            src_sel_q     <= (state_d == S_RUN);
            pipe_enable_q <= (state_d == S_INIT) || (state_d == S_RUN);
            busy_q        <= (state_d == S_INIT) || (state_d == S_RUN);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign src_sel     = src_sel_q;
    assign pipe_enable = pipe_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign gen_count   = gen_count_q;

endmodule

// File: tb/tb_ga_gen_ctrl.sv
// Directed bench: vector table for reset/first generation/tie/start-ignore/reset-mid-run,
// hand sequences for generation limit, stagnation and target termination.
module tb_ga_gen_ctrl;

    localparam longint FMIN = -67108864;

    logic              clk = 1'b0;
    logic              reset, start, pair_valid, target_en;
    logic [7:0]        chrom1, chrom2;
    logic signed [26:0] fit1, fit2, target_fit;

    logic               a_src, a_pipe, a_busy, a_done;
    logic [15:0]        a_gen;
    logic [7:0]         a_best;
    logic signed [26:0] a_fit;
    logic               b_src, b_pipe, b_busy, b_done;
    logic [15:0]        b_gen;
    logic [7:0]         b_best;
    logic signed [26:0] b_fit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ga_gen_ctrl #(.MAX_GENS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start), .pair_valid(pair_valid),
        .chrom1(chrom1), .chrom2(chrom2), .fit1(fit1), .fit2(fit2),
        .target_en(target_en), .target_fit(target_fit),
        .src_sel(a_src), .pipe_enable(a_pipe), .busy(a_busy), .done(a_done),
        .gen_count(a_gen), .best(a_best), .best_fit(a_fit)
    );

    ga_gen_ctrl #(.STALL_LIMIT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .pair_valid(pair_valid),
        .chrom1(chrom1), .chrom2(chrom2), .fit1(fit1), .fit2(fit2),
        .target_en(target_en), .target_fit(target_fit),
        .src_sel(b_src), .pipe_enable(b_pipe), .busy(b_busy), .done(b_done),
        .gen_count(b_gen), .best(b_best), .best_fit(b_fit)
    );

    typedef struct {
        logic               rst;
        logic               st;
        logic               pv;
        logic [7:0]         c1;
        logic [7:0]         c2;
        logic signed [26:0] f1;
        logic signed [26:0] f2;
        logic [7:0]         e_best;
        longint             e_fit;
        int                 e_gen;
        logic               e_busy;
        logic               e_done;
        logic               e_src;
        logic               e_pipe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic st, logic pv, logic [7:0] c1, logic [7:0] c2,
                                longint f1, longint f2, logic [7:0] e_best, longint e_fit,
                                int e_gen, logic e_busy, logic e_done, logic e_src, logic e_pipe);
        vec_t v;
        v.rst = rst; v.st = st; v.pv = pv; v.c1 = c1; v.c2 = c2;
        v.f1 = 27'(f1); v.f2 = 27'(f2);
        v.e_best = e_best; v.e_fit = e_fit; v.e_gen = e_gen;
        v.e_busy = e_busy; v.e_done = e_done; v.e_src = e_src; v.e_pipe = e_pipe;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; pair_valid = 1'b0;
        chrom1 = '0; chrom2 = '0; fit1 = '0; fit2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pair(input logic [7:0] c1, input logic [7:0] c2,
                        input longint f1, input longint f2);
        pair_valid = 1'b1;
        chrom1 = c1; chrom2 = c2;
        fit1 = 27'(f1); fit2 = 27'(f2);
        tick();
        pair_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        target_en  = 1'b0;
        target_fit = '0;

        // Reset, idle, start, first generation, tie, ignored start, reset mid-run.
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, FMIN, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, FMIN, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, FMIN, 0, 1, 0, 0, 1));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 0, 1, 8'(i), 8'(8'h80 | i), i, -i, 8'(i), i,
                             (i == 7) ? 1 : 0, 1, 0, (i == 7), 1));
        end
        tbl.push_back(mk(0, 0, 1, 8'hAA, 8'h55, 9, 9, 8'hAA, 9, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'hAA, 9, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'h01, 8'h02, 3, 5, 8'hAA, 9, 1, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 8'hEE, 8'hEE, 500, 500, 8'h00, FMIN, 0, 0, 0, 0, 0));

        for (int r = 0; r < tbl.size(); r++) begin
            reset = tbl[r].rst; start = tbl[r].st; pair_valid = tbl[r].pv;
            chrom1 = tbl[r].c1; chrom2 = tbl[r].c2; fit1 = tbl[r].f1; fit2 = tbl[r].f2;
            tick();
            chk($sformatf("row%0d best", r),     a_best, tbl[r].e_best);
            chk($sformatf("row%0d best_fit", r), a_fit,  tbl[r].e_fit);
            chk($sformatf("row%0d gen", r),      a_gen,  tbl[r].e_gen);
            chk($sformatf("row%0d busy", r),     a_busy, tbl[r].e_busy);
            chk($sformatf("row%0d done", r),     a_done, tbl[r].e_done);
            chk($sformatf("row%0d src_sel", r),  a_src,  tbl[r].e_src);
            chk($sformatf("row%0d pipe_en", r),  a_pipe, tbl[r].e_pipe);
        end
        idle_inputs();

        // Generation limit of 3 on dut_a with rising fitness.
        do_reset();
        do_start();
        for (int k = 1; k <= 24; k++) begin
            pair(8'(k), 8'h00, k, -1);
            if (k == 8)  chk("lim gen1 busy", a_busy, 1);
            if (k == 16) begin
                chk("lim gen2 count", a_gen, 2);
                chk("lim gen2 done", a_done, 0);
            end
        end
        chk("lim done", a_done, 1);
        chk("lim gen", a_gen, 3);
        chk("lim busy", a_busy, 0);
        chk("lim pipe_en", a_pipe, 0);
        chk("lim best", a_best, 24);
        pair(8'hFF, 8'hFF, 1000, 1000);
        chk("lim post best", a_best, 24);
        chk("lim post fit", a_fit, 24);
        chk("lim post gen", a_gen, 3);
        chk("lim post done", a_done, 1);
        do_start();
        chk("restart done", a_done, 0);
        chk("restart busy", a_busy, 1);
        chk("restart gen", a_gen, 0);
        chk("restart fit", a_fit, FMIN);

        // Stagnation of 2 generations on dut_b.
        do_reset();
        do_start();
        for (int j = 0; j < 8; j++) pair((j == 3) ? 8'h32 : 8'(j), 8'h00, (j == 3) ? 50 : 10, 0);
        chk("stall g1 fit", b_fit, 50);
        chk("stall g1 src", b_src, 1);
        for (int j = 0; j < 8; j++) pair(8'(8'hC0 | j), 8'h00, (j == 5) ? 50 : 20, 0);
        chk("stall g2 done", b_done, 0);
        chk("stall g2 gen", b_gen, 2);
        for (int j = 0; j < 8; j++) pair(8'(j), 8'h77, j, (j == 0) ? 50 : 0);
        chk("stall done", b_done, 1);
        chk("stall gen", b_gen, 3);
        chk("stall fit", b_fit, 50);
        chk("stall best", b_best, 8'h32);

        // Target fitness, checked only at generation end.
        do_reset();
        target_en  = 1'b1;
        target_fit = 27'sd100;
        do_start();
        for (int j = 0; j < 8; j++) pair(8'(j + 1), 8'h00, j + 1, -5);
        chk("tgt g1 done", b_done, 0);
        for (int j = 0; j < 8; j++) begin
            pair((j == 1) ? 8'h64 : 8'h01, 8'h00, (j == 1) ? 100 : 0, 0);
            if (j == 1) begin
                chk("tgt mid busy", b_busy, 1);
                chk("tgt mid done", b_done, 0);
                chk("tgt mid fit", b_fit, 100);
            end
        end
        chk("tgt done", b_done, 1);
        chk("tgt gen", b_gen, 2);
        chk("tgt best", b_best, 8'h64);
        target_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
